// File: rtl/cc_alu_sequencer.sv
// rtl/cc_alu_sequencer.sv - command sequencer in front of the combinational 8-bit ALU
//
// Purpose: accepts an ALU command (op, A, B, repeat count) on a valid/ready
// handshake, runs it Repeat+1 times on the external ALU, and feeds each result
// back as operand A. It then returns the final result and active-high flags on
// a second valid/ready handshake.
//
// Ports:
//   CC_ALUSEQ_CLOCK_50, CC_ALUSEQ_RESET_InHigh      clock, async active-high reset
//   CC_ALUSEQ_Cmd*                                  command channel (valid/ready, op, A, B, repeat)
//   CC_ALUSEQ_ALUDataBUSA/B_Out, ALUSelection_Out   operands and op code to the ALU
//   CC_ALUSEQ_ALUDataBUS_In, ALU*_InLow             ALU result and active-low flags
//   CC_ALUSEQ_Rsp*                                  response channel (valid/ready, data, {N,Z,V,C})
module cc_alu_sequencer #(
  parameter int DATAWIDTH_BUS           = 8,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int DATAWIDTH_REPEAT        = 4
) (
  input  logic                               CC_ALUSEQ_CLOCK_50,
  input  logic                               CC_ALUSEQ_RESET_InHigh,
  input  logic                               CC_ALUSEQ_CmdValid_InHigh,
  output logic                               CC_ALUSEQ_CmdReady_OutHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_CmdOp_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_CmdA_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_CmdB_In,
  input  logic [DATAWIDTH_REPEAT-1:0]        CC_ALUSEQ_CmdRepeat_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_ALUDataBUSA_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_ALUDataBUSB_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_ALUSelection_Out,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_ALUDataBUS_In,
  input  logic                               CC_ALUSEQ_ALUOverflow_InLow,
  input  logic                               CC_ALUSEQ_ALUCarry_InLow,
  input  logic                               CC_ALUSEQ_ALUNegative_InLow,
  input  logic                               CC_ALUSEQ_ALUZero_InLow,
  output logic                               CC_ALUSEQ_RspValid_OutHigh,
  input  logic                               CC_ALUSEQ_RspReady_InHigh,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_RspData_Out,
  output logic [3:0]                         CC_ALUSEQ_RspFlags_Out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [DATAWIDTH_REPEAT-1:0] COUNT_ONE = {{(DATAWIDTH_REPEAT-1){1'b0}}, 1'b1};

  state_t                             state_q, state_d;
  logic [DATAWIDTH_ALU_SELECTION-1:0] op_q, op_d;
  logic [DATAWIDTH_BUS-1:0]           a_q, a_d;   // working A; holds the final result in RESP
  logic [DATAWIDTH_BUS-1:0]           b_q, b_d;
  logic [DATAWIDTH_REPEAT-1:0]        count_q, count_d;
  logic                               n_q, n_d, z_q, z_d;
  logic                               c_q, c_d, v_q, v_d;   // sticky across iterations

  always_ff @(posedge CC_ALUSEQ_CLOCK_50 or posedge CC_ALUSEQ_RESET_InHigh) begin
    if (CC_ALUSEQ_RESET_InHigh) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (CC_ALUSEQ_CmdValid_InHigh) begin
          op_d    = CC_ALUSEQ_CmdOp_In;
          a_d     = CC_ALUSEQ_CmdA_In;
          b_d     = CC_ALUSEQ_CmdB_In;
          count_d = CC_ALUSEQ_CmdRepeat_In;
          c_d     = 1'b0;
          v_d     = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // ALU is combinational on the registered operands, so its result is
        // valid by the end of this same cycle.
        a_d = CC_ALUSEQ_ALUDataBUS_In;
        n_d = ~CC_ALUSEQ_ALUNegative_InLow;
        z_d = ~CC_ALUSEQ_ALUZero_InLow;
        c_d = c_q | ~CC_ALUSEQ_ALUCarry_InLow;
        v_d = v_q | ~CC_ALUSEQ_ALUOverflow_InLow;
        if (count_q == '0) begin
          state_d = RESP;
        end else begin
          count_d = count_q - COUNT_ONE;
        end
      end
      RESP: begin
        if (CC_ALUSEQ_RspReady_InHigh) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and registers, so an async reset drives them
  // to idle values without waiting for a clock edge.
  always_comb begin
    CC_ALUSEQ_CmdReady_OutHigh = (state_q == IDLE);
    CC_ALUSEQ_RspValid_OutHigh = (state_q == RESP);
    CC_ALUSEQ_ALUDataBUSA_Out  = '0;
    CC_ALUSEQ_ALUDataBUSB_Out  = '0;
    CC_ALUSEQ_ALUSelection_Out = '1;   // all-ones is the ALU's do-nothing code
    CC_ALUSEQ_RspData_Out      = '0;
    CC_ALUSEQ_RspFlags_Out     = 4'b0000;
    if (state_q == ISSUE) begin
      CC_ALUSEQ_ALUDataBUSA_Out  = a_q;
      CC_ALUSEQ_ALUDataBUSB_Out  = b_q;
      CC_ALUSEQ_ALUSelection_Out = op_q;
    end
    if (state_q == RESP) begin
      CC_ALUSEQ_RspData_Out  = a_q;
      CC_ALUSEQ_RspFlags_Out = {n_q, z_q, v_q, c_q};
    end
  end

endmodule

// File: tb/tb_cc_alu_sequencer.sv
// tb/tb_cc_alu_sequencer.sv - directed self-checking bench for cc_alu_sequencer
module tb_cc_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_rep;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [3:0] alu_sel;
  logic       alu_v_n, alu_c_n, alu_n_n, alu_z_n;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;

  int checks = 0;
  int errors = 0;
  logic [7:0] seen_a[$];

  always #5 clk = ~clk;

  cc_alu_sequencer dut (
    .CC_ALUSEQ_CLOCK_50         (clk),
    .CC_ALUSEQ_RESET_InHigh     (rst),
    .CC_ALUSEQ_CmdValid_InHigh  (cmd_valid),
    .CC_ALUSEQ_CmdReady_OutHigh (cmd_ready),
    .CC_ALUSEQ_CmdOp_In         (cmd_op),
    .CC_ALUSEQ_CmdA_In          (cmd_a),
    .CC_ALUSEQ_CmdB_In          (cmd_b),
    .CC_ALUSEQ_CmdRepeat_In     (cmd_rep),
    .CC_ALUSEQ_ALUDataBUSA_Out  (alu_a),
    .CC_ALUSEQ_ALUDataBUSB_Out  (alu_b),
    .CC_ALUSEQ_ALUSelection_Out (alu_sel),
    .CC_ALUSEQ_ALUDataBUS_In    (alu_res),
    .CC_ALUSEQ_ALUOverflow_InLow(alu_v_n),
    .CC_ALUSEQ_ALUCarry_InLow   (alu_c_n),
    .CC_ALUSEQ_ALUNegative_InLow(alu_n_n),
    .CC_ALUSEQ_ALUZero_InLow    (alu_z_n),
    .CC_ALUSEQ_RspValid_OutHigh (rsp_valid),
    .CC_ALUSEQ_RspReady_InHigh  (rsp_ready),
    .CC_ALUSEQ_RspData_Out      (rsp_data),
    .CC_ALUSEQ_RspFlags_Out     (rsp_flags)
  );

  // Combinational ALU: 1000 ADD, 1001 SUB (carry = borrow), 1010 INC A, else pass A.
  always_comb begin
    logic [8:0] t;
    logic       c, v;
    t = {1'b0, alu_a};
    c = 1'b0;
    v = 1'b0;
    case (alu_sel)
      4'b1000: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        c = t[8];
        v = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'b1001: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        c = (alu_a < alu_b);
        v = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'b1010: begin
        t = {1'b0, alu_a} + 9'd1;
        c = t[8];
        v = (alu_a == 8'h7F);
      end
      default: ;
    endcase
    alu_res = t[7:0];
    alu_c_n = ~c;
    alu_v_n = ~v;
    alu_n_n = ~t[7];
    alu_z_n = ~(t[7:0] == 8'h00);
  end

  // Issue one command, wait for the response, check latency/data/flags, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] rep, input logic [7:0] ed, input logic [3:0] ef,
                        input string name);
    int cyc;
    seen_a.delete();
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_rep = rep; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready before accept: got %b want 1", name, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      seen_a.push_back(alu_a);
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != int'(rep) + 1) begin
      errors++; $display("FAIL %s latency: got %0d edges want %0d", name, cyc, int'(rep) + 1);
    end
    checks++;
    if (rsp_data !== ed) begin
      errors++; $display("FAIL %s data: got %h want %h", name, rsp_data, ed);
    end
    checks++;
    if (rsp_flags !== ef) begin
      errors++; $display("FAIL %s flags: got %b want %b", name, rsp_flags, ef);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_sel !== 4'b1111) begin
      errors++; $display("FAIL %s after handshake: valid=%b ready=%b sel=%b want 0 1 1111",
                         name, rsp_valid, cmd_ready, alu_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_rep = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_flags !== 4'h0 ||
        alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 4'b1111) begin
      errors++; $display("FAIL reset values: rdy=%b vld=%b d=%h f=%b a=%h b=%h sel=%b",
                         cmd_ready, rsp_valid, rsp_data, rsp_flags, alu_a, alu_b, alu_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_ops();
    run_op(4'b1000, 8'h05, 8'h03, 4'd0, 8'h08, 4'b0000, "add");
    run_op(4'b1000, 8'h7F, 8'h01, 4'd0, 8'h80, 4'b1010, "overflow");
    run_op(4'b1001, 8'h03, 8'h03, 4'd0, 8'h00, 4'b0100, "sub_zero");
  endtask

  task automatic test_iterated();
    run_op(4'b1000, 8'hF0, 8'h10, 4'd1, 8'h10, 4'b0001, "iter_add");
    checks++;
    if (seen_a.size() != 2 || seen_a[0] !== 8'hF0 || seen_a[1] !== 8'h00) begin
      errors++; $display("FAIL iter_add bus A sequence: got %p want F0,00", seen_a);
    end
    // FE -> FF -> 00 (carry) -> 01
    run_op(4'b1010, 8'hFE, 8'h00, 4'd2, 8'h01, 4'b0001, "iter_inc");
    // Max repeat with a pass-A code: 16 iterations, value unchanged.
    run_op(4'b0101, 8'h5A, 8'h33, 4'd15, 8'h5A, 4'b0000, "pass_max_rep");
    checks++;
    if (seen_a.size() != 16 || seen_a[15] !== 8'h5A) begin
      errors++; $display("FAIL pass_max_rep iterations: got %0d want 16", seen_a.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    cmd_op = 4'b1000; cmd_a = 8'h20; cmd_b = 8'h22; cmd_rep = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = i[0]; cmd_a = 8'hAA; cmd_op = 4'b1001;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h42 || rsp_flags !== 4'b0000 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure hold %0d: vld=%b d=%h f=%b rdy=%b want 1 42 0000 0",
                           i, rsp_valid, rsp_data, rsp_flags, cmd_ready);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_sel !== 4'b1111) begin
      errors++; $display("FAIL backpressure release: rdy=%b vld=%b sel=%b want 1 0 1111",
                         cmd_ready, rsp_valid, alu_sel);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    @(negedge clk);
    cmd_op = 4'b1010; cmd_a = 8'h10; cmd_b = 8'h00; cmd_rep = 4'd7; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_sel !== 4'b1010 || alu_a !== 8'h11 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid-issue state: sel=%b a=%h rdy=%b want 1010 11 0", alu_sel, alu_a, cmd_ready);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
        alu_sel !== 4'b1111 || rsp_data !== 8'h00 || rsp_flags !== 4'h0) begin
      errors++; $display("FAIL async reset: rdy=%b vld=%b a=%h b=%h sel=%b d=%h f=%b",
                         cmd_ready, rsp_valid, alu_a, alu_b, alu_sel, rsp_data, rsp_flags);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL aborted command: rsp_valid cycles=%0d rdy=%b want 0 1", seen, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_iterated();
    test_backpressure();
    test_async_reset();
    run_op(4'b1000, 8'h01, 8'h02, 4'd0, 8'h03, 4'b0000, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_alu_sequencer.md
Name: cc_alu_sequencer

Overview:
- Command front-end that drives the 8-bit ALU's operand buses and selection code, and captures the ALU result and active-low flags.
- Accepts operation commands over a valid/ready handshake and optionally iterates the operation, feeding each result back as operand A.
- Returns the final result plus active-high accumulated flags over a second valid/ready handshake.
- Sits between the datapath control and the combinational ALU.

Parameters:
DATAWIDTH_BUS, 8, width of operand/result buses
DATAWIDTH_ALU_SELECTION, 4, width of ALU operation code
DATAWIDTH_REPEAT, 4, width of iteration count field

Ports:
CC_ALUSEQ_CLOCK_50  in  1  system clock, rising edge
CC_ALUSEQ_RESET_InHigh  in  1  asynchronous reset, active-high
CC_ALUSEQ_CmdValid_InHigh  in  1  command valid
CC_ALUSEQ_CmdReady_OutHigh  out  1  command accepted when high with valid
CC_ALUSEQ_CmdOp_In  in  DATAWIDTH_ALU_SELECTION  ALU selection code
CC_ALUSEQ_CmdA_In  in  DATAWIDTH_BUS  initial operand A
CC_ALUSEQ_CmdB_In  in  DATAWIDTH_BUS  operand B, constant for all iterations
CC_ALUSEQ_CmdRepeat_In  in  DATAWIDTH_REPEAT  extra iterations (0 = execute once)
CC_ALUSEQ_ALUDataBUSA_Out  out  DATAWIDTH_BUS  to ALU bus A
CC_ALUSEQ_ALUDataBUSB_Out  out  DATAWIDTH_BUS  to ALU bus B
CC_ALUSEQ_ALUSelection_Out  out  DATAWIDTH_ALU_SELECTION  to ALU selection
CC_ALUSEQ_ALUDataBUS_In  in  DATAWIDTH_BUS  ALU result
CC_ALUSEQ_ALUOverflow_InLow / ALUCarry_InLow / ALUNegative_InLow / ALUZero_InLow  in  1 each  ALU flags, active-low
CC_ALUSEQ_RspValid_OutHigh  out  1  response valid
CC_ALUSEQ_RspReady_InHigh  in  1  response consumer ready
CC_ALUSEQ_RspData_Out  out  DATAWIDTH_BUS  final result
CC_ALUSEQ_RspFlags_Out  out  4  {N,Z,V,C}, active-high

Behaviour:
- Clocking and reset: one clock, CC_ALUSEQ_CLOCK_50. Reset CC_ALUSEQ_RESET_InHigh is asynchronous and active-high.
- Reset values:
  - state IDLE, CmdReady=1, RspValid=0, RspData=0, RspFlags=0.
  - ALU bus A=0, ALU bus B=0, ALUSelection=4'b1111 (do nothing).
  - Internal op/B/count/accumulator registers = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - CmdReady=1; ALU outputs at idle values.
  - On CmdValid&CmdReady: latch Op, A, B, Repeat into registers; clear the sticky C/V accumulators; go to ISSUE.
- ISSUE:
  - Each ISSUE cycle is one iteration. Drive bus A = working A, bus B = latched B, ALUSelection = latched Op, all from registers. The ALU is combinational and settles within the cycle.
  - At the clock edge ending the cycle:
    - working A <= ALUDataBUS_In.
    - N <= ~ALUNegative_InLow; Z <= ~ALUZero_InLow.
    - Csticky |= ~ALUCarry_InLow; Vsticky |= ~ALUOverflow_InLow.
  - If count==0, go to RESP; else count-1 and stay in ISSUE.
- RESP:
  - RspValid=1; RspData = last captured result; RspFlags = {N, Z, Vsticky, Csticky}. ALU outputs return to idle values.
  - Data and flags stay stable while RspReady=0.
  - On RspValid&RspReady go to IDLE. CmdReady rises the following cycle; no command is accepted in the handshake cycle.
- Handshakes: CmdReady=0 in ISSUE and RESP, and CmdValid is ignored there.
- Latency: with the command accepted at edge k, RspValid is high from cycle k+Repeat+2, i.e. Repeat+1 ISSUE cycles.
- Widths: all operand arithmetic is done by the ALU; the count decrements without wrap, exiting at 0. Max Repeat=15 gives 16 iterations.
- Op codes: passed through unchanged, including the 0101–0111 and 1100–1111 pass-A codes. Flags are recorded exactly as the ALU reports them, regardless of op.
- Reset mid-operation: immediate return to reset values; any in-flight command is discarded and no response is issued.
- CmdValid and reset deasserting in the same cycle: the command is not accepted until the first edge after reset release.

Test Plan:
- Single ADD: Op=1000, A=8'h05, B=8'h03, Repeat=0 -> RspData=8'h08, RspFlags=4'b0000, RspValid 2 cycles after accept.
- Overflow: Op=1000, A=8'h7F, B=8'h01, Repeat=0 -> RspData=8'h80, RspFlags=4'b1010 (N=1, V=1).
- Iterated ADD with sticky carry: Op=1000, A=8'hF0, B=8'h10, Repeat=1 -> ALU sees A=F0 then A=00. RspData=8'h10, RspFlags=4'b0001 (C sticky from first iteration). RspValid 3 cycles after accept.
- Zero result: Op=1001, A=8'h03, B=8'h03, Repeat=0 -> RspData=8'h00, RspFlags=4'b0100. Also Op=1010, A=8'hFE, B=0, Repeat=2 -> RspData=8'h01.
- Backpressure: hold RspReady=0 for 5 cycles in RESP while pulsing CmdValid -> RspValid, RspData and RspFlags stable; CmdReady=0; no new command latched. Release -> IDLE, CmdReady=1 one cycle later.
- Async reset: assert reset mid-ISSUE of a Repeat=7 command -> outputs reach reset values without a clock edge. After release, CmdReady=1, RspValid never asserts for the aborted command.
